// File: rtl/handshake_burst_src.sv
// ============================================================================
//  Module      : handshake_burst_src
//  Description : Valid/ready burst source. Accepts one command (base, length,
//                trailing gap) and emits LEN+1 incrementing beats, holding
//                each beat stable under backpressure, followed by an
//                optional idle gap before the next command is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_burst_src #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   // command side
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_base_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic [GAP_W-1:0] cmd_gap_i,
   // stream side
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o,
   output logic             done_o,
   output logic [LEN_W-1:0] beat_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;     // beats minus one of the burst in flight
   logic [GAP_W-1:0] gap_cnt;   // latched gap, then counts down in ST_GAP

   logic             beat_xfer;
   logic [LEN_W-1:0] cnt_next;

   // A beat leaves only on the valid/ready handshake.
   assign beat_xfer = valid_o && ready_i;
   // beat_cnt_o is always below len_q when a non-last beat moves, so no wrap.
   assign cnt_next  = beat_cnt_o + 1'b1;

   // Burst sequencer: all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cmd_ready_o <= 1'b0;
         valid_o     <= 1'b0;
         data_o      <= '0;
         last_o      <= 1'b0;
         done_o      <= 1'b0;
         beat_cnt_o  <= '0;
         len_q       <= '0;
         gap_cnt     <= '0;
      end else begin
         // done_o is a single-cycle pulse unless re-asserted below.
         done_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               valid_o <= 1'b0;
               if (cmd_valid_i && cmd_ready_o) begin
                  // Fields are captured here only; later changes are ignored.
                  len_q       <= cmd_len_i;
                  gap_cnt     <= cmd_gap_i;
                  cmd_ready_o <= 1'b0;
                  valid_o     <= 1'b1;
                  data_o      <= cmd_base_i;
                  beat_cnt_o  <= '0;
                  last_o      <= (cmd_len_i == '0);
                  state       <= ST_SEND;
               end else begin
                  // Also covers the first cycle out of reset.
                  cmd_ready_o <= 1'b1;
               end
            end

            ST_SEND: begin
               if (beat_xfer) begin
                  if (last_o) begin
                     valid_o <= 1'b0;
                     last_o  <= 1'b0;
                     data_o  <= '0;
                     done_o  <= 1'b1;
                     if (gap_cnt == '0) begin
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                     end else begin
                        state <= ST_GAP;
                     end
                  end else begin
                     // Back-to-back beats, no bubble.
                     data_o     <= data_o + 1'b1;
                     beat_cnt_o <= cnt_next;
                     last_o     <= (cnt_next == len_q);
                  end
               end
               // Without a handshake every stream output simply holds.
            end

            ST_GAP: begin
               // The done cycle is the first idle cycle, so the ready
               // rises after exactly gap_cnt cycles from the last transfer.
               if (gap_cnt == {{(GAP_W-1){1'b0}}, 1'b1}) begin
                  cmd_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b0;
               valid_o     <= 1'b0;
               last_o      <= 1'b0;
               data_o      <= '0;
               beat_cnt_o  <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_handshake_burst_src.sv
// ============================================================================
//  Module      : tb_handshake_burst_src
//  Description : Directed and randomized self-checking bench for
//                handshake_burst_src.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_handshake_burst_src;

   localparam int WIDTH = 32;
   localparam int LEN_W = 8;
   localparam int GAP_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [WIDTH-1:0] cmd_base_i;
   logic [LEN_W-1:0] cmd_len_i;
   logic [GAP_W-1:0] cmd_gap_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic             last_o;
   logic             done_o;
   logic [LEN_W-1:0] beat_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   handshake_burst_src #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_base_i  (cmd_base_i),
      .cmd_len_i   (cmd_len_i),
      .cmd_gap_i   (cmd_gap_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .last_o      (last_o),
      .done_o      (done_o),
      .beat_cnt_o  (beat_cnt_o)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a command; the accept edge is the following tick.
   task automatic issue(input logic [31:0] base, input logic [7:0] len, input logic [3:0] gap);
      cmd_valid_i = 1'b1;
      cmd_base_i  = base;
      cmd_len_i   = len;
      cmd_gap_i   = gap;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   // Test 3 vectors: per-cycle ready and the beat expected on the bus.
   logic [31:0] t3_data [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
   logic [7:0]  t3_cnt  [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
   logic        t3_last [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        t3_rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   // Hard stop in case something hangs despite the bounded loops.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] base, e_data;
      logic [7:0]  len;
      logic [3:0]  gap;
      logic        r;
      int          idx, cyc, k;

      rst         = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_base_i  = '0;
      cmd_len_i   = '0;
      cmd_gap_i   = '0;
      ready_i     = 1'b0;

      // ---- 1: reset values, ready rises on first edge out of reset ----
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_outputs", {cmd_ready_o, valid_o, last_o, done_o, beat_cnt_o, data_o}, 64'd0);
      end
      rst = 1'b0;
      tick();
      chk("ready_after_reset", {cmd_ready_o, valid_o, done_o}, 3'b100);

      // ---- 2: base 0x10, len 3, gap 0, ready high ----
      ready_i = 1'b1;
      issue(32'h10, 8'd3, 4'd0);
      chk("t2_cmd_ready_low", cmd_ready_o, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("t2_beat", {valid_o, last_o, beat_cnt_o, data_o},
             {1'b1, (i == 3), 8'(i), 32'h10 + 32'(i)});
         chk("t2_no_done", done_o, 1'b0);
         tick();
      end
      chk("t2_done", {done_o, cmd_ready_o, valid_o, last_o, data_o}, {4'b1100, 32'd0});
      tick();
      chk("t2_done_pulse_end", {done_o, cmd_ready_o}, 2'b01);

      // ---- 3: wrap-around with ready toggling 1,0,0,1,1 ----
      issue(32'hFFFF_FFFE, 8'd2, 4'd0);
      for (int i = 0; i < 5; i++) begin
         ready_i = t3_rdy[i];
         chk("t3_beat", {valid_o, last_o, beat_cnt_o, data_o},
             {1'b1, t3_last[i], t3_cnt[i], t3_data[i]});
         tick();
      end
      chk("t3_done", {done_o, valid_o, cmd_ready_o}, 3'b101);
      ready_i = 1'b1;
      tick();

      // ---- 4: single beat, gap 5, command held high through the gap ----
      issue(32'h55, 8'd0, 4'd5);
      chk("t4_beat", {valid_o, last_o, beat_cnt_o, data_o}, {1'b1, 1'b1, 8'd0, 32'h55});
      cmd_valid_i = 1'b1;
      cmd_base_i  = 32'hAA;
      cmd_len_i   = 8'd0;
      cmd_gap_i   = 4'd0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_gap", {cmd_ready_o, valid_o, done_o}, {2'b00, (i == 0)});
         tick();
      end
      chk("t4_ready_after_gap", {cmd_ready_o, valid_o}, 2'b10);
      tick();
      cmd_valid_i = 1'b0;
      chk("t4_second_cmd", {valid_o, last_o, cmd_ready_o, data_o}, {3'b110, 32'hAA});
      tick();
      chk("t4_second_done", {done_o, cmd_ready_o}, 2'b11);
      tick();

      // ---- 5: reset while beat 2 of len 7 is stalled ----
      issue(32'h100, 8'd7, 4'd3);
      chk("t5_beat0", data_o, 32'h100);
      tick();
      chk("t5_beat1", data_o, 32'h101);
      tick();
      ready_i = 1'b0;
      chk("t5_beat2", {beat_cnt_o, data_o}, {8'd2, 32'h102});
      tick();
      chk("t5_stall_hold", {valid_o, beat_cnt_o, data_o}, {1'b1, 8'd2, 32'h102});
      rst = 1'b1;
      tick();
      chk("t5_reset_outputs", {cmd_ready_o, valid_o, last_o, done_o, beat_cnt_o, data_o}, 64'd0);
      rst     = 1'b0;
      ready_i = 1'b1;
      tick();
      chk("t5_after_reset", {cmd_ready_o, valid_o, done_o}, 3'b100);
      issue(32'h200, 8'd1, 4'd0);
      chk("t5_new_beat0", {valid_o, last_o, beat_cnt_o, data_o}, {2'b10, 8'd0, 32'h200});
      tick();
      chk("t5_new_beat1", {valid_o, last_o, beat_cnt_o, data_o}, {2'b11, 8'd1, 32'h201});
      tick();
      chk("t5_new_done", done_o, 1'b1);
      tick();

      // ---- maximum length: 256 beats, counter reaches 255 ----
      issue(32'h0, 8'd255, 4'd0);
      for (int i = 0; i < 256; i++) begin
         chk("max_len_beat", {valid_o, last_o, beat_cnt_o, data_o},
             {1'b1, (i == 255), 8'(i), 32'(i)});
         tick();
      end
      chk("max_len_done", {done_o, valid_o}, 2'b10);
      tick();

      // ---- 6: 200 random commands, random backpressure ----
      for (int c = 0; c < 200; c++) begin
         base = $urandom;
         len  = 8'($urandom_range(0, 5));
         gap  = 4'($urandom_range(0, 3));
         chk("rnd_cmd_ready", cmd_ready_o, 1'b1);
         issue(base, len, gap);
         idx = 0;
         cyc = 0;
         while (idx <= int'(len) && cyc < 100) begin
            r           = 1'($urandom_range(0, 1));
            ready_i     = r;
            // Noise on the command port must be ignored mid-burst.
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_base_i  = $urandom;
            cmd_len_i   = 8'($urandom);
            cmd_gap_i   = 4'($urandom);
            e_data      = base + 32'(idx);
            chk("rnd_beat", {valid_o, last_o, beat_cnt_o, data_o, done_o},
                {1'b1, (idx == int'(len)), 8'(idx), e_data, 1'b0});
            tick();
            cyc++;
            if (r) idx++;
         end
         cmd_valid_i = 1'b0;
         chk("rnd_burst_complete", (idx > int'(len)), 1'b1);
         chk("rnd_done", {done_o, valid_o}, 2'b10);
         k = 0;
         while (!cmd_ready_o && k < 20) begin
            chk("rnd_gap_idle", valid_o, 1'b0);
            k++;
            tick();
         end
         chk("rnd_gap_len", 64'(k), 64'(gap));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
